// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: holds the {N,Z,C} flag register and resolves KGP-RISC
// branches against it, one request at a time.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   flag_we, neg_in/zero_in/carry_in ALU flag commit
//   br_valid/br_ready                request handshake
//   cond, pc_in, offset, reg_target  branch request payload
//   flags_q                          architectural {N,Z,C}
//   resolve_valid, taken             resolution pulse
//   redirect_valid, redirect_pc      fetch redirect pulse and address
//   link_we, link_addr               link register write (bl only)
//   flush                            kill window after a taken branch
module branch_resolve_unit #(
  parameter int unsigned PC_W         = 32,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flag_we,
  input  logic            neg_in,
  input  logic            zero_in,
  input  logic            carry_in,
  input  logic            br_valid,
  output logic            br_ready,
  input  logic [2:0]      cond,
  input  logic [PC_W-1:0] pc_in,
  input  logic [PC_W-1:0] offset,
  input  logic [PC_W-1:0] reg_target,
  output logic [2:0]      flags_q,
  output logic            resolve_valid,
  output logic            taken,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  output logic            link_we,
  output logic [PC_W-1:0] link_addr,
  output logic            flush
);

  localparam int unsigned CNT_W = 4;
  localparam logic [2:0]  COND_B    = 3'd0;
  localparam logic [2:0]  COND_BR   = 3'd1;
  localparam logic [2:0]  COND_BLTZ = 3'd2;
  localparam logic [2:0]  COND_BZ   = 3'd3;
  localparam logic [2:0]  COND_BNZ  = 3'd4;
  localparam logic [2:0]  COND_BL   = 3'd5;
  localparam logic [2:0]  COND_BCY  = 3'd6;
  localparam logic [2:0]  COND_BNCY = 3'd7;

  typedef enum logic [1:0] {IDLE, EVAL, REDIRECT} state_t;

  state_t          state;
  logic [2:0]      cond_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] off_q;
  logic [PC_W-1:0] tgt_q;
  logic [CNT_W-1:0] cnt;

  logic            take_c;
  logic [PC_W-1:0] target_c;

  assign br_ready = (state == IDLE);

  // Flag register, independent of branch activity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 3'b000;
    end else if (flag_we) begin
      flags_q <= {neg_in, zero_in, carry_in};
    end
  end

  // Condition decode against the flags as seen during EVAL.
  always_comb begin
    take_c = 1'b0;
    case (cond_q)
      COND_B, COND_BR, COND_BL: take_c = 1'b1;
      COND_BLTZ:                take_c = flags_q[2];
      COND_BZ:                  take_c = flags_q[1];
      COND_BNZ:                 take_c = ~flags_q[1];
      COND_BCY:                 take_c = flags_q[0];
      COND_BNCY:                take_c = ~flags_q[0];
      default:                  take_c = 1'b0;
    endcase
  end

  // Word offset scaled to bytes; wrap-around is intentionally silent.
  always_comb begin
    target_c = pc_q + (off_q << 2);
    if (cond_q == COND_BR) target_c = tgt_q;
  end

  // Request capture, resolution and flush window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cond_q         <= 3'd0;
      pc_q           <= '0;
      off_q          <= '0;
      tgt_q          <= '0;
      cnt            <= '0;
      resolve_valid  <= 1'b0;
      taken          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      link_we        <= 1'b0;
      link_addr      <= '0;
      flush          <= 1'b0;
    end else begin
      resolve_valid  <= 1'b0;
      taken          <= 1'b0;
      redirect_valid <= 1'b0;
      link_we        <= 1'b0;
      case (state)
        IDLE: begin
          if (br_valid) begin
            cond_q <= cond;
            pc_q   <= pc_in;
            off_q  <= offset;
            tgt_q  <= reg_target;
            state  <= EVAL;
          end
        end
        EVAL: begin
          resolve_valid <= 1'b1;
          taken         <= take_c;
          if (take_c) begin
            redirect_valid <= 1'b1;
            redirect_pc    <= target_c;
            flush          <= 1'b1;
            cnt            <= CNT_W'(FLUSH_CYCLES - 1);
            state          <= REDIRECT;
            if (cond_q == COND_BL) begin
              link_we   <= 1'b1;
              link_addr <= pc_q + PC_W'(4);
            end
          end else begin
            state <= IDLE;
          end
        end
        REDIRECT: begin
          if (cnt == '0) begin
            flush <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: a transaction-level model predicts
// per-cycle outputs from accept time, a compare process checks every negedge,
// and literal checks pin the model on the hand-worked cases.
module tb_branch_resolve_unit;

  localparam int FL = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flag_we = 1'b0, neg_in = 1'b0, zero_in = 1'b0, carry_in = 1'b0;
  logic        br_valid = 1'b0;
  logic        br_ready;
  logic [2:0]  cond = 3'd0;
  logic [31:0] pc_in = '0, offset = '0, reg_target = '0;
  logic [2:0]  flags_q;
  logic        resolve_valid, taken, redirect_valid, link_we, flush;
  logic [31:0] redirect_pc, link_addr;

  int checks = 0;
  int errors = 0;

  branch_resolve_unit #(.PC_W(32), .FLUSH_CYCLES(FL)) dut (
    .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .neg_in(neg_in),
    .zero_in(zero_in), .carry_in(carry_in), .br_valid(br_valid),
    .br_ready(br_ready), .cond(cond), .pc_in(pc_in), .offset(offset),
    .reg_target(reg_target), .flags_q(flags_q), .resolve_valid(resolve_valid),
    .taken(taken), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .link_we(link_we), .link_addr(link_addr), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic branch_taken(input logic [2:0] c, input logic [2:0] f);
    case (c)
      3'd2:    return f[2];
      3'd3:    return f[1];
      3'd4:    return !f[1];
      3'd6:    return f[0];
      3'd7:    return !f[0];
      default: return 1'b1;
    endcase
  endfunction

  // Model: cycle n counts edges since reset; a request accepted on the edge
  // leaving cycle k resolves in cycle k+2 and frees the unit by schedule.
  int          n = 0, ready_cyc = 0, res_cyc = -1, old_n = 0;
  logic        m_taken = 1'b0, m_bl = 1'b0;
  logic [2:0]  m_flags = 3'b000;
  logic [31:0] m_target = '0, m_link = '0, e_rpc = '0, e_link = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n = 0; ready_cyc = 0; res_cyc = -1; m_taken = 1'b0; m_bl = 1'b0;
      m_flags = 3'b000; e_rpc = '0; e_link = '0;
    end else begin
      old_n = n;
      n = n + 1;
      if (flag_we) m_flags = {neg_in, zero_in, carry_in};
      if (br_valid && old_n >= ready_cyc) begin
        m_taken   = branch_taken(cond, m_flags);
        m_bl      = (cond == 3'd5);
        m_target  = (cond == 3'd1) ? reg_target : pc_in + offset * 4;
        m_link    = pc_in + 32'd4;
        res_cyc   = old_n + 2;
        ready_cyc = m_taken ? old_n + 2 + FL : old_n + 2;
      end
      if (n == res_cyc && m_taken) begin
        e_rpc = m_target;
        if (m_bl) e_link = m_link;
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    logic rv;
    rv = (n == res_cyc);
    chk("br_ready",       32'(br_ready),       32'(n >= ready_cyc));
    chk("flags_q",        32'(flags_q),        32'(m_flags));
    chk("resolve_valid",  32'(resolve_valid),  32'(rv));
    chk("taken",          32'(taken),          32'(rv && m_taken));
    chk("redirect_valid", 32'(redirect_valid), 32'(rv && m_taken));
    chk("link_we",        32'(link_we),        32'(rv && m_taken && m_bl));
    chk("flush",          32'(flush),          32'(m_taken && n >= res_cyc && n < res_cyc + FL));
    chk("redirect_pc",    redirect_pc,         e_rpc);
    chk("link_addr",      link_addr,           e_link);
  end

  // Present a request from the next negedge and hold it until accepted;
  // returns at the negedge of the EVAL cycle.
  task automatic req(input logic [2:0] c, input logic [31:0] p, input logic [31:0] o,
                     input logic [31:0] r, output int waited);
    waited = 0;
    @(negedge clk);
    br_valid = 1'b1; cond = c; pc_in = p; offset = o; reg_target = r;
    while (!br_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!br_ready) begin
      checks++; errors++;
      $display("FAIL req_timeout: br_ready stayed 0 after %0d cycles", waited);
    end
    @(negedge clk);
    br_valid = 1'b0; cond = 3'd0; pc_in = 32'hDEAD_BEEF; offset = 32'h1234_5678;
  endtask

  task automatic set_flags(input logic nn, input logic zz, input logic cc);
    @(negedge clk);
    flag_we = 1'b1; neg_in = nn; zero_in = zz; carry_in = cc;
    @(negedge clk);
    flag_we = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (!br_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!br_ready) begin
      checks++; errors++;
      $display("FAIL idle_timeout: br_ready stayed 0 after %0d cycles", k);
    end
  endtask

  initial begin
    int w;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(br_ready), 32'd1);
    chk("rst_flush", 32'(flush), 32'd0);
    rst_n = 1'b1;

    // bz taken, flags Z=1 written the cycle before
    set_flags(1'b0, 1'b1, 1'b0);
    req(3'd3, 32'h100, 32'h10, 32'h0, w);
    @(negedge clk);
    chk("bz_rv", 32'(resolve_valid), 32'd1);
    chk("bz_taken", 32'(taken), 32'd1);
    chk("bz_rpc", redirect_pc, 32'h140);
    chk("bz_flush1", 32'(flush), 32'd1);
    @(negedge clk);
    chk("bz_flush2", 32'(flush), 32'd1);
    chk("bz_busy", 32'(br_ready), 32'd0);
    @(negedge clk);
    chk("bz_flush_end", 32'(flush), 32'd0);
    chk("bz_ready", 32'(br_ready), 32'd1);

    // bncy not taken with C=1
    set_flags(1'b0, 1'b0, 1'b1);
    req(3'd7, 32'h180, 32'h4, 32'h0, w);
    @(negedge clk);
    chk("bncy_rv", 32'(resolve_valid), 32'd1);
    chk("bncy_taken", 32'(taken), 32'd0);
    chk("bncy_redv", 32'(redirect_valid), 32'd0);
    chk("bncy_flush", 32'(flush), 32'd0);
    chk("bncy_ready", 32'(br_ready), 32'd1);

    // bl with negative offset, then br via register
    req(3'd5, 32'h200, 32'hFFFF_FFFC, 32'h0, w);
    @(negedge clk);
    chk("bl_rpc", redirect_pc, 32'h1F0);
    chk("bl_lwe", 32'(link_we), 32'd1);
    chk("bl_link", link_addr, 32'h204);
    req(3'd1, 32'h300, 32'h40, 32'hABCD_0000, w);
    @(negedge clk);
    chk("br_rpc", redirect_pc, 32'hABCD_0000);
    chk("br_lwe", 32'(link_we), 32'd0);
    chk("br_link_hold", link_addr, 32'h204);

    // bltz: N=1 written on the accept edge counts, N=0 during EVAL does not
    wait_idle();
    br_valid = 1'b1; cond = 3'd2; pc_in = 32'h400; offset = 32'h2;
    flag_we = 1'b1; neg_in = 1'b1; zero_in = 1'b0; carry_in = 1'b0;
    @(negedge clk);
    br_valid = 1'b0; neg_in = 1'b0;
    @(negedge clk);
    flag_we = 1'b0;
    chk("bltz_rv", 32'(resolve_valid), 32'd1);
    chk("bltz_taken", 32'(taken), 32'd1);
    chk("bltz_flags", 32'(flags_q), 32'd0);

    // wrap-around target, then a request held through REDIRECT
    req(3'd0, 32'hFFFF_FFF0, 32'h8, 32'h0, w);
    req(3'd4, 32'h300, 32'h1, 32'h0, w);
    chk("bp_wait", 32'(w), 32'd2);
    chk("wrap_rpc", redirect_pc, 32'h10);
    @(negedge clk);
    chk("bnz_rpc", redirect_pc, 32'h304);
    chk("bnz_taken", 32'(taken), 32'd1);

    // reset in the middle of a flush window
    req(3'd0, 32'h500, 32'h0, 32'h0, w);
    @(negedge clk);
    chk("pre_rst_flush", 32'(flush), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_flush", 32'(flush), 32'd0);
    chk("arst_rpc", redirect_pc, 32'd0);
    chk("arst_link", link_addr, 32'd0);
    chk("arst_flags", 32'(flags_q), 32'd0);
    chk("arst_rv", 32'(resolve_valid | redirect_valid | link_we | taken), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(br_ready), 32'd1);
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
